// File: rtl/spi_master_io.sv
// spi_master_io
//   CPU-bus responder for the FE00 IO page: four byte registers driving an SPI
//   master (mode 0, MSB first, one byte per transfer, polled through STATUS).
//
//   Ports
//     clk_i, rst_i          system clock / asynchronous active-high reset
//     spi_cs, R_W_n         register select (one cycle per access), read(1)/write(0)
//     reg_addr [1:0]        0 DATA, 1 STATUS, 2 CTRL, 3 CLKDIV
//     data_i [7:0]          CPU write data
//     data_o [7:0]          read data, combinational from reg_addr
//     spi_sclk_o            SPI clock, idle low
//     spi_mosi_o            SPI data out, idle high
//     spi_miso_i            SPI data in, asynchronous to clk_i
//     spi_cs_n_o            card select, software controlled via CTRL bit 0
module spi_master_io #(
    parameter logic [7:0] DIV_RESET = 8'd99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_cs,
    input  logic       R_W_n,
    input  logic [1:0] reg_addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_n_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_FINISH} state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] div_q, div_d;
    logic [7:0] hm_q, hm_d;      // latched half period minus one
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic [1:0] miso_s_q;

    logic wr, rd, busy;
    logic [7:0] div_clamp;

    assign wr        = spi_cs & ~R_W_n;
    assign rd        = spi_cs & R_W_n;
    assign busy      = (state_q != S_IDLE);
    // Half period is at least 3 cycles so the synchronized MISO sample taken at
    // the end of HIGH reflects a bit the slave drove before the rising edge.
    assign div_clamp = (div_q < 8'd2) ? 8'd2 : div_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        div_d   = div_q;
        hm_d    = hm_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        cs_n_d  = cs_n_q;

        if (wr && reg_addr == 2'd2) cs_n_d = data_i[0];
        if (wr && reg_addr == 2'd3) div_d  = data_i;
        if (wr && reg_addr == 2'd1 && data_i[2]) ovr_d = 1'b0;
        if (wr && reg_addr == 2'd0 && busy)      ovr_d = 1'b1;
        // Reading DATA clears DONE; FINISH below overrides so a racing read
        // never loses completion.
        if (rd && reg_addr == 2'd0) done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr && reg_addr == 2'd0) begin
                    shift_d = data_i;
                    bit_d   = 3'd7;
                    done_d  = 1'b0;
                    hm_d    = div_clamp;
                    cnt_d   = div_clamp;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = hm_q;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == 8'd0) begin
                    shift_d = {shift_q[6:0], miso_s_q[1]};
                    if (bit_q == 3'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        cnt_d   = hm_q;
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_FINISH: begin
                rx_d    = shift_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from next state so they change cleanly on the edge.
        sclk_d = (state_d == S_HIGH);
        mosi_d = (state_d == S_LOW || state_d == S_HIGH) ? shift_d[7] : 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            rx_q     <= 8'h00;
            div_q    <= DIV_RESET;
            hm_q     <= 8'd2;
            cnt_q    <= 8'd0;
            bit_q    <= 3'd0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            miso_s_q <= 2'b11;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            rx_q     <= rx_d;
            div_q    <= div_d;
            hm_q     <= hm_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            miso_s_q <= {miso_s_q[0], spi_miso_i};
        end
    end

    always_comb begin
        case (reg_addr)
            2'd0:    data_o = rx_q;
            2'd1:    data_o = {5'b0, ovr_q, done_q, busy};
            2'd2:    data_o = {7'b0, cs_n_q};
            default: data_o = div_q;
        endcase
    end

    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master_io.sv
module tb_spi_master_io;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       spi_cs = 1'b0;
    logic       R_W_n = 1'b1;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       spi_sclk_o, spi_mosi_o, spi_cs_n_o;
    logic       spi_miso_i;

    spi_master_io dut (
        .clk_i(clk_i), .rst_i(rst_i), .spi_cs(spi_cs), .R_W_n(R_W_n),
        .reg_addr(reg_addr), .data_i(data_i), .data_o(data_o),
        .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o),
        .spi_miso_i(spi_miso_i), .spi_cs_n_o(spi_cs_n_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_ctr = 0;

    always @(posedge clk_i) cyc_ctr <= cyc_ctr + 1;

    // SPI slave model (mode 0): captures MOSI on SCLK rise, presents next TX
    // bit after each SCLK fall. Loopback mode ties MISO straight to MOSI.
    int         rises = 0, falls = 0, base_f = 0, s_k;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_tx = 8'hFF;
    logic       loopb = 1'b0;

    always @(posedge spi_sclk_o) begin
        rises <= rises + 1;
        s_sh  <= {s_sh[6:0], spi_mosi_o};
    end
    always @(negedge spi_sclk_o) falls <= falls + 1;

    always_comb begin
        s_k = falls - base_f;
        if (loopb)                  spi_miso_i = spi_mosi_o;
        else if (s_k >= 0 && s_k < 8) spi_miso_i = s_tx[7 - s_k];
        else                        spi_miso_i = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slave_load(input logic [7:0] b);
        s_tx   = b;
        base_f = falls;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk_i);
        spi_cs = 1'b1; R_W_n = 1'b0; reg_addr = a; data_i = d;
        @(negedge clk_i);
        spi_cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk_i);
        spi_cs = 1'b1; R_W_n = 1'b1; reg_addr = a;
        #1 d = data_o;
        @(negedge clk_i);
        spi_cs = 1'b0;
    endtask

    // Poll BUSY passively (STATUS via data_o, no bus access) until it drops.
    // dur = cycles since c0; hi = cycles seen with SCLK high.
    task automatic wait_idle(input int c0, output int dur, output int hi);
        int n;
        n = 0; hi = 0;
        reg_addr = 2'd1;
        #1;
        while (data_o[0] && n < 4000) begin
            if (spi_sclk_o) hi++;
            @(negedge clk_i);
            n++;
        end
        dur = cyc_ctr - c0;
        chk("busy_timeout", (n < 4000) ? 1 : 0, 1);
    endtask

    function automatic int half(input logic [7:0] div);
        return ((div < 2) ? 2 : int'(div)) + 1;
    endfunction

    logic [7:0] rd_v, b, sb, prev_rx, dv;
    int dur, hi, c0, r0, n, h, j;

    initial begin
        // 1 reset
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_sclk", spi_sclk_o, 0);
        chk("rst_mosi", spi_mosi_o, 1);
        chk("rst_csn",  spi_cs_n_o, 1);
        cpu_rd(0, rd_v); chk("rst_data",   rd_v, 8'h00);
        cpu_rd(1, rd_v); chk("rst_status", rd_v, 8'h00);
        cpu_rd(2, rd_v); chk("rst_ctrl",   rd_v, 8'h01);
        cpu_rd(3, rd_v); chk("rst_clkdiv", rd_v, 8'd99);

        // 2 loopback, CLKDIV=3
        cpu_wr(3, 8'd3);
        cpu_wr(2, 8'h00);
        chk("t2_csn", spi_cs_n_o, 0);
        loopb = 1'b1;
        r0 = rises;
        cpu_wr(0, 8'hA5);
        c0 = cyc_ctr;
        wait_idle(c0, dur, hi);
        chk("t2_busy", dur, 16 * 4 + 1);
        chk("t2_hi",   hi, 8 * 4);
        chk("t2_rises", rises - r0, 8);
        chk("t2_mosi", s_sh, 8'hA5);
        cpu_rd(1, rd_v); chk("t2_st_done", rd_v, 8'h02);
        cpu_rd(0, rd_v); chk("t2_rx", rd_v, 8'hA5);
        cpu_rd(1, rd_v); chk("t2_st_clr", rd_v, 8'h00);
        loopb = 1'b0;

        // 3 clamp, MISO 0
        slave_load(8'h00);
        cpu_wr(3, 8'd0);
        cpu_wr(0, 8'h3C);
        c0 = cyc_ctr;
        wait_idle(c0, dur, hi);
        chk("t3_busy", dur, 16 * 3 + 1);
        chk("t3_hi",   hi, 8 * 3);
        chk("t3_mosi", s_sh, 8'h3C);
        cpu_rd(0, rd_v); chk("t3_rx", rd_v, 8'h00);
        cpu_rd(3, rd_v); chk("t3_div", rd_v, 8'h00);

        // 4 overrun + mid-transfer CLKDIV write
        sb = 8'($urandom);
        slave_load(sb);
        cpu_wr(3, 8'd1);
        r0 = rises;
        cpu_wr(0, 8'hFF);
        c0 = cyc_ctr;
        cpu_wr(0, 8'h11);
        cpu_rd(1, rd_v); chk("t4_st_ovr", rd_v, 8'h05);
        cpu_wr(3, 8'd7);
        wait_idle(c0, dur, hi);
        chk("t4_busy", dur, 16 * 3 + 1);
        chk("t4_rises", rises - r0, 8);
        chk("t4_mosi", s_sh, 8'hFF);
        cpu_rd(1, rd_v); chk("t4_st_06", rd_v, 8'h06);
        cpu_wr(1, 8'h04);
        cpu_rd(1, rd_v); chk("t4_st_02", rd_v, 8'h02);
        cpu_rd(0, rd_v); chk("t4_rx", rd_v, sb);

        // 5 reset at bit 3
        cpu_wr(2, 8'h00);
        cpu_wr(3, 8'd2);
        slave_load(8'h5A);
        r0 = rises;
        cpu_wr(0, 8'hC3);
        n = 0;
        while ((rises - r0) < 4 && n < 500) begin @(negedge clk_i); n++; end
        chk("t5_reach", (n < 500) ? 1 : 0, 1);
        rst_i = 1'b1;
        #1;
        chk("t5_sclk", spi_sclk_o, 0);
        chk("t5_mosi", spi_mosi_o, 1);
        chk("t5_csn",  spi_cs_n_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        r0 = rises;
        repeat (80) @(negedge clk_i);
        chk("t5_no_sclk", rises - r0, 0);
        cpu_rd(1, rd_v); chk("t5_status", rd_v, 8'h00);
        cpu_rd(0, rd_v); chk("t5_rx", rd_v, 8'h00);

        // 6 random transfers, DATA reads racing FINISH
        prev_rx = 8'h00;
        for (int i = 0; i < 256; i++) begin
            dv = 8'($urandom_range(0, 4));
            h  = half(dv);
            b  = 8'($urandom);
            sb = 8'($urandom);
            cpu_wr(3, dv);
            slave_load(sb);
            cpu_wr(0, b);
            c0 = cyc_ctr;
            j = $urandom_range(16 * h - 3, 16 * h + 1);
            repeat (j - 1) @(negedge clk_i);
            spi_cs = 1'b1; R_W_n = 1'b1; reg_addr = 2'd0;
            #1 chk("t6_oldrx", data_o, prev_rx);
            @(negedge clk_i);
            spi_cs = 1'b0;
            wait_idle(c0, dur, hi);
            chk("t6_busy", dur, 16 * h + 1);
            cpu_rd(1, rd_v); chk("t6_done_kept", rd_v, 8'h02);
            cpu_rd(0, rd_v); chk("t6_rx", rd_v, sb);
            chk("t6_mosi", s_sh, b);
            prev_rx = sb;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
